// File: rtl/slice_add_seq_if.sv
// Operand/result handshake bundle for the slice-serial adder.
// The master side issues operands and consumes results; the slave side is the sequencer.
interface slice_add_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow, busy
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, overflow, busy
  );
endinterface

// File: rtl/slice_add_seq.sv
// WIDTH-bit add/subtract computed one 4-bit slice per clock through a single
// shared 4-bit adder, with a registered carry between slices.
module full_adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;

  always_comb begin
    c[0] = ci;
    s    = '0;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[4];
  end
endmodule

module slice_add_seq #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  slice_add_seq_if.slave bus
);
  localparam int NSLICE = WIDTH / 4;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("slice_add_seq: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       carry_q, carry_d;
  logic [NSLICE-1:0][3:0]     a_q, a_d;
  logic [NSLICE-1:0][3:0]     b_q, b_d;
  logic [NSLICE-1:0][3:0]     sum_q, sum_d;
  logic                       c_out_q, c_out_d;
  logic                       ovf_q, ovf_d;

  logic [3:0] fa_s;
  logic       fa_co;

  full_adder4 u_slice (
    .a  (a_q[idx_q]),
    .b  (b_q[idx_q]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Subtraction folds into addition: A + ~B + 1, so c_in is unused then.
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.c_in;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q] = fa_s;
        carry_d      = fa_co;
        idx_d        = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          c_out_d = fa_co;
          ovf_d   = (a_q[NSLICE-1][3] == b_q[NSLICE-1][3]) && (fa_s[3] != a_q[NSLICE-1][3]);
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_slice_add_seq.sv
// Directed bench for slice_add_seq: arithmetic vectors, latency, backpressure
// and asynchronous reset in the middle of an operation.
module tb_slice_add_seq;
  localparam int WIDTH = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  slice_add_seq_if #(.WIDTH(WIDTH)) bus ();

  slice_add_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, wait for the result, check it, then complete the handshake.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic sb, input logic [15:0] esum,
                        input logic ec, input logic eov);
    int lat;
    bus.a        = av;
    bus.b        = bv;
    bus.c_in     = ci;
    bus.sub      = sb;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = 16'($urandom);
    bus.b        = 16'($urandom);
    bus.c_in     = 1'($urandom);
    bus.sub      = 1'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      check({tag, " in_ready_run"}, 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd4);
    check({tag, " sum"}, 32'(bus.sum), 32'(esum));
    check({tag, " c_out"}, 32'(bus.c_out), 32'(ec));
    check({tag, " overflow"}, 32'(bus.overflow), 32'(eov));
    check({tag, " busy_done"}, 32'(bus.busy), 32'd1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, " out_valid_drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, " in_ready_back"}, 32'(bus.in_ready), 32'd1);
    check({tag, " sum_kept"}, 32'(bus.sum), 32'(esum));
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.c_in      = 1'b0;
    bus.sub       = 1'b0;
    #1;
    check("rst in_ready", 32'(bus.in_ready), 32'd1);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst sum", 32'(bus.sum), 32'd0);
    check("rst c_out", 32'(bus.c_out), 32'd0);
    check("rst overflow", 32'(bus.overflow), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_basic", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
    run_op("ripple_all", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("cin_only", 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
    run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("sub_cin_ign", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // Backpressure: result 0x0F0F + 0x00F1 = 0x1000 held while new operands wave around.
    bus.a        = 16'h0F0F;
    bus.b        = 16'h00F1;
    bus.c_in     = 1'b0;
    bus.sub      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("bp out_valid_rise", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = 16'(i * 16'h1357);
      bus.b        = 16'(i * 16'h0F0F);
      bus.sub      = i[0];
      check("bp out_valid", 32'(bus.out_valid), 32'd1);
      check("bp sum", 32'(bus.sum), 32'h1000);
      check("bp c_out", 32'(bus.c_out), 32'd0);
      check("bp overflow", 32'(bus.overflow), 32'd0);
      check("bp in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    check("bp held_sum", 32'(bus.sum), 32'h1000);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp idle_out_valid", 32'(bus.out_valid), 32'd0);
    check("bp idle_in_ready", 32'(bus.in_ready), 32'd1);
    run_op("after_bp", 16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

    // Asynchronous reset with the slice index at 2.
    bus.a        = 16'hFFFF;
    bus.b        = 16'hFFFF;
    bus.c_in     = 1'b1;
    bus.sub      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mrst sum", 32'(bus.sum), 32'd0);
    check("mrst out_valid", 32'(bus.out_valid), 32'd0);
    check("mrst busy", 32'(bus.busy), 32'd0);
    check("mrst in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule
